alu_commit_arbiter: RTL and testbench
=====================================

// Module: alu_commit_arbiter
// PURPOSE
//  Commit-side endpoint of the ALU result protocol (valid/res/o_rd/o_error/clear).
//  - Collects finished results from N_CH ALU channels; one is granted per cycle (round-robin).
//  - Writes the granted result into the register-file write port.
//  - Acknowledges the channel with a one-cycle clear pulse.
//  - Routes errored results (e.g. divide-by-zero) to an exception handshake instead of the RF.
// PARAMETERS
//  N_CH        4                           number of ALU result channels
//  XLEN        core_config_pkg::XLEN       data width (32)
//  REG_ADDR_W  core_config_pkg::REG_ADDR_W destination register index width (5)
// PORTS
//  clk        in   1                  single clock; all logic on rising edge
//  rst        in   1                  synchronous, active-high reset
//  ch_valid   in   N_CH               channel i holds a finished result (level, held until clear)
//  ch_res     in   N_CH*XLEN          channel i result data
//  ch_rd      in   N_CH*REG_ADDR_W    channel i destination register
//  ch_error   in   N_CH               channel i result is an error
//  ch_req     in   N_CH               reserved; ignored
//  ch_clear   out  N_CH               one-cycle acknowledge pulse to channel i
//  wb_en      out  1                  register-file write enable
//  wb_rd      out  REG_ADDR_W         register-file write address
//  wb_data    out  XLEN               register-file write data
//  exc_valid  out  1                  captured error pending
//  exc_ch     out  $clog2(N_CH)       channel that raised the error
//  exc_rd     out  REG_ADDR_W         destination register of the errored op
//  exc_ack    in   1                  consumer accepts the pending error
//  commit_cnt out  32                 count of results retired (written or excepted)
// BEHAVIOUR
//  Reset: all outputs 0, rr_ptr=0, clear_q=0, commit_cnt=0. Reset mid-operation drops
//   any pending capture. ALUs still holding valid are re-arbitrated after reset.
//  Eligibility (cycle t): elig = ch_valid & ~clear_q & {N_CH{~stall}}.
//   - stall = exc_valid & ~exc_ack.
//   - clear_q masks the channel still showing valid in the cycle after its clear.
//  Grant: first set bit of elig searching rr_ptr, rr_ptr+1, ... (mod N_CH).
//   - On a grant g: rr_ptr <= (g+1) mod N_CH. No grant leaves rr_ptr unchanged.
//  Capture: a grant at edge end of t updates registered outputs valid in t+1.
//   - ch_clear[g]=1 for exactly cycle t+1; all other bits 0.
//   - If ch_error[g]=0: wb_en=(ch_rd[g]!=0), wb_rd=ch_rd[g], wb_data=ch_res[g]. x0 writes suppressed.
//   - If ch_error[g]=1: wb_en=0; exc_valid<=1, exc_ch<=g, exc_rd<=ch_rd[g].
//   - commit_cnt+1 either way, including rd=0. commit_cnt wraps at 2^32.
//   - With no grant: wb_en=0, ch_clear=0; wb_rd/wb_data hold their last values.
//  Latency 1 cycle valid->wb_en. Throughput 1 commit/cycle across channels.
//   Per channel: at most one commit per 2 cycles (masking).
//  Exception: exc_valid holds until exc_ack, then clears next edge.
//   - While exc_valid & ~exc_ack, no grants (commit stalls; ALUs stay valid).
//   - exc_ack with a new errored grant in the same cycle: the new error loads
//     (set wins over clear).
//   - exc_ack with exc_valid=0 is ignored.
//  FSM per channel (implicit via clear_q): IDLE -> (granted) CLEARING 1 cycle -> IDLE.
// STRUCTURE
//  core_config_pkg: XLEN, REG_ADDR_W, N_ALU (default for N_CH), commit_t struct {rd,data,err}.
//  Sub-module rr_arbiter #(N): req[N], advance -> gnt onehot, gnt_idx, any.
//   - rr_ptr lives inside rr_arbiter.
//  Top holds the capture registers, clear_q, the exception register and commit_cnt.
// TESTING
//  1 Single: ch1 valid, rd=7, res=0xDEADBEEF
//      -> next cycle wb_en=1, wb_rd=7, wb_data=0xDEADBEEF, ch_clear=0010; commit_cnt=1.
//  2 Fairness: all 4 valid and held from reset (ch_valid stays 1111; no ALU drops valid)
//      -> grants 0,1,2,3,0... Each is masked the cycle after its own clear.
//  3 x0: ch2 valid rd=0 -> wb_en=0, ch_clear[2]=1, commit_cnt increments.
//  4 Error: ch3 error rd=9 -> exc_valid=1, exc_ch=3, exc_rd=9, wb_en=0.
//      - ch0 valid meanwhile stays ungranted until exc_ack; it commits the cycle after the ack.
//  5 Ack+new error: exc_ack coincides with errored grant on ch1
//      -> exc_valid stays 1, exc_ch=1.
//  6 Reset mid-op: rst during a grant cycle -> all outputs 0 next cycle.
//      - rr_ptr=0; the held valid on ch2 is re-granted after rst deasserts.

Source files
------------

// File: rtl/core_config_pkg.sv
// -----------------------------------------------------------------------------
// core_config_pkg
//   Core-wide configuration shared by the ALU result protocol blocks.
//   - XLEN        : datapath width
//   - REG_ADDR_W  : register-file index width
//   - N_ALU       : number of ALU result channels (default commit fan-in)
//   - commit_t    : one retiring result {rd, data, err}
//   - idx_width() : width of an index into n items (never below 1 bit)
// -----------------------------------------------------------------------------
package core_config_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned N_ALU      = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
        logic                  err;
    } commit_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter over N requesters. The search starts at rr_ptr and
//   wraps; after a grant the pointer moves to the slot just past the winner,
//   so the winner has lowest priority next time. No grant, no pointer move.
// Ports
//   clk      in   1       rising-edge clock
//   rst      in   1       synchronous active-high reset (rr_ptr -> 0)
//   req      in   N       request vector
//   advance  in   1       arbitration enabled this cycle; gates grants too
//   gnt      out  N       one-hot grant (all zero when no grant)
//   gnt_idx  out  IDX_W   index of the granted requester
//   any      out  1       a grant was made this cycle
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = core_config_pkg::idx_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] cand;

    // Walk the requesters in priority order rr_ptr, rr_ptr+1, ... (mod N);
    // the first one found wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        if (advance) begin
            for (int unsigned off = 0; off < N; off++) begin
                cand = IDX_W'((32'(rr_ptr) + off) % N);
                if (!any && req[cand]) begin
                    any          = 1'b1;
                    gnt[cand]    = 1'b1;
                    gnt_idx      = cand;
                end
            end
        end
        ptr_next = IDX_W'((32'(gnt_idx) + 1) % N);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (any) begin
            rr_ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/alu_commit_arbiter.sv
// -----------------------------------------------------------------------------
// alu_commit_arbiter
//   Commit-side endpoint of the ALU result protocol. Each cycle one eligible
//   channel is granted round-robin; its result is registered onto the RF
//   write port (or into the exception register if errored), and the channel
//   gets a one-cycle ch_clear acknowledge in the following cycle.
// Ports
//   clk         in   1               rising-edge clock
//   rst         in   1               synchronous active-high reset
//   ch_valid    in   N_CH            channel holds a finished result
//   ch_res      in   N_CH*XLEN       per-channel result data
//   ch_rd       in   N_CH*REG_ADDR_W per-channel destination register
//   ch_error    in   N_CH            per-channel error flag
//   ch_req      in   N_CH            reserved, ignored
//   ch_clear    out  N_CH            one-cycle acknowledge pulse
//   wb_en       out  1               RF write enable (suppressed for x0)
//   wb_rd       out  REG_ADDR_W      RF write address
//   wb_data     out  XLEN            RF write data
//   exc_valid   out  1               captured error pending
//   exc_ch      out  clog2(N_CH)     channel that raised the error
//   exc_rd      out  REG_ADDR_W      destination of the errored op
//   exc_ack     in   1               consumer accepts the pending error
//   commit_cnt  out  32              results retired (written or excepted)
// -----------------------------------------------------------------------------
module alu_commit_arbiter #(
    parameter int unsigned N_CH       = core_config_pkg::N_ALU,
    parameter int unsigned XLEN       = core_config_pkg::XLEN,
    parameter int unsigned REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            ch_valid,
    input  logic [N_CH*XLEN-1:0]       ch_res,
    input  logic [N_CH*REG_ADDR_W-1:0] ch_rd,
    input  logic [N_CH-1:0]            ch_error,
    input  logic [N_CH-1:0]            ch_req,
    output logic [N_CH-1:0]            ch_clear,
    output logic                       wb_en,
    output logic [REG_ADDR_W-1:0]      wb_rd,
    output logic [XLEN-1:0]            wb_data,
    output logic                       exc_valid,
    output logic [$clog2(N_CH)-1:0]    exc_ch,
    output logic [REG_ADDR_W-1:0]      exc_rd,
    input  logic                       exc_ack,
    output logic [31:0]                commit_cnt
);

    import core_config_pkg::*;

    localparam int unsigned IDX_W = $clog2(N_CH);

    logic                  stall;
    logic [N_CH-1:0]       clear_q;
    logic [N_CH-1:0]       elig;
    logic [N_CH-1:0]       gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  any;
    logic [XLEN-1:0]       sel_res;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic                  sel_err;
    logic                  unused_req;

    assign unused_req = ^ch_req;

    // An unacknowledged exception blocks all commits; ALUs simply keep
    // holding valid until it drains.
    assign stall = exc_valid & ~exc_ack;

    // A channel still shows valid in the cycle its clear pulse is out, so
    // it is masked for that one cycle to avoid committing it twice.
    assign elig = ch_valid & ~clear_q & {N_CH{~stall}};

    rr_arbiter #(
        .N     (N_CH),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .advance (~stall),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // One-hot grant drives an AND-OR select of the winner's payload.
    always_comb begin
        sel_res = '0;
        sel_rd  = '0;
        sel_err = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (gnt[i]) begin
                sel_res = ch_res[i*XLEN +: XLEN];
                sel_rd  = ch_rd[i*REG_ADDR_W +: REG_ADDR_W];
                sel_err = ch_error[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clear_q    <= '0;
            wb_en      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            exc_valid  <= 1'b0;
            exc_ch     <= '0;
            exc_rd     <= '0;
            commit_cnt <= '0;
        end else begin
            clear_q <= gnt;
            wb_en   <= any & ~sel_err & (sel_rd != '0);

            if (any && !sel_err) begin
                wb_rd   <= sel_rd;
                wb_data <= sel_res;
            end

            if (any) begin
                commit_cnt <= commit_cnt + 32'd1;
            end

            // A new errored grant takes priority over the ack of the old one.
            if (any && sel_err) begin
                exc_valid <= 1'b1;
                exc_ch    <= gnt_idx;
                exc_rd    <= sel_rd;
            end else if (exc_ack) begin
                exc_valid <= 1'b0;
            end
        end
    end

    assign ch_clear = clear_q;

endmodule

// File: tb/tb_alu_commit_arbiter.sv
module tb_alu_commit_arbiter;

    localparam int N  = 4;
    localparam int XW = 32;
    localparam int RW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    ch_valid;
    logic [N*XW-1:0] ch_res;
    logic [N*RW-1:0] ch_rd;
    logic [N-1:0]    ch_error;
    logic [N-1:0]    ch_req;
    logic [N-1:0]    ch_clear;
    logic            wb_en;
    logic [RW-1:0]   wb_rd;
    logic [XW-1:0]   wb_data;
    logic            exc_valid;
    logic [1:0]      exc_ch;
    logic [RW-1:0]   exc_rd;
    logic            exc_ack;
    logic [31:0]     commit_cnt;

    alu_commit_arbiter #(
        .N_CH       (N),
        .XLEN       (XW),
        .REG_ADDR_W (RW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_valid   (ch_valid),
        .ch_res     (ch_res),
        .ch_rd      (ch_rd),
        .ch_error   (ch_error),
        .ch_req     (ch_req),
        .ch_clear   (ch_clear),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .exc_valid  (exc_valid),
        .exc_ch     (exc_ch),
        .exc_rd     (exc_rd),
        .exc_ack    (exc_ack),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural ALU channels: each holds one result until acknowledged.
    logic          a_valid [N];
    logic [RW-1:0] a_rd    [N];
    logic [XW-1:0] a_res   [N];
    logic          a_err   [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ch_valid[i]           = a_valid[i];
            ch_error[i]           = a_err[i];
            ch_rd[i*RW +: RW]     = a_rd[i];
            ch_res[i*XW +: XW]    = a_res[i];
        end
    end

    // Reference model state
    int            m_ptr;
    int            m_last;
    logic          m_exc_valid;
    int            m_exc_ch;
    logic [RW-1:0] m_exc_rd;
    logic          m_wb_en;
    logic [RW-1:0] m_wb_rd;
    logic [XW-1:0] m_wb_data;
    logic [31:0]   m_cnt;
    logic [N-1:0]  m_clear;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int g;
        int c;
        g = -1;
        if (rst) begin
            m_ptr = 0; m_last = -1; m_exc_valid = 1'b0; m_exc_ch = 0; m_exc_rd = '0;
            m_wb_en = 1'b0; m_wb_rd = '0; m_wb_data = '0; m_cnt = '0; m_clear = '0;
            return;
        end
        if (!(m_exc_valid && exc_ack)) begin
            if (!m_exc_valid) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (g < 0 && a_valid[c] && c != m_last) g = c;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (g < 0 && a_valid[c] && c != m_last) g = c;
            end
        end
        m_clear = '0;
        m_wb_en = 1'b0;
        if (m_exc_valid && exc_ack) m_exc_valid = 1'b0;
        if (g >= 0) begin
            m_clear[g] = 1'b1;
            m_ptr      = (g + 1) % N;
            m_cnt      = m_cnt + 32'd1;
            if (a_err[g]) begin
                m_exc_valid = 1'b1;
                m_exc_ch    = g;
                m_exc_rd    = a_rd[g];
            end else begin
                m_wb_en   = (a_rd[g] != 0);
                m_wb_rd   = a_rd[g];
                m_wb_data = a_res[g];
            end
        end
        m_last = g;
    endtask

    task automatic load_new(input int i);
        a_valid[i] = 1'b1;
        a_rd[i]    = ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom);
        a_res[i]   = $urandom;
        a_err[i]   = ($urandom_range(0, 7) == 0);
    endtask

    // mode 0: channels hold; 1: drop valid on clear; 2: random traffic
    task automatic alu_react(input int mode);
        for (int i = 0; i < N; i++) begin
            if (mode == 1 && m_clear[i]) a_valid[i] = 1'b0;
            if (mode == 2) begin
                if (m_clear[i]) begin
                    if ($urandom_range(0, 1) == 0) a_valid[i] = 1'b0;
                    else load_new(i);
                end else if (!a_valid[i] && $urandom_range(0, 2) == 0) begin
                    load_new(i);
                end
            end
        end
    endtask

    task automatic step(input int mode);
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("ch_clear", 64'(ch_clear), 64'(m_clear));
        chk("wb_en", 64'(wb_en), 64'(m_wb_en));
        chk("wb_rd", 64'(wb_rd), 64'(m_wb_rd));
        chk("wb_data", 64'(wb_data), 64'(m_wb_data));
        chk("exc_valid", 64'(exc_valid), 64'(m_exc_valid));
        chk("commit_cnt", 64'(commit_cnt), 64'(m_cnt));
        if (m_exc_valid) begin
            chk("exc_ch", 64'(exc_ch), 64'(m_exc_ch));
            chk("exc_rd", 64'(exc_rd), 64'(m_exc_rd));
        end
        alu_react(mode);
    endtask

    task automatic set_ch(input int i, input logic v, input logic [RW-1:0] rd,
                          input logic [XW-1:0] res, input logic err);
        a_valid[i] = v;
        a_rd[i]    = rd;
        a_res[i]   = res;
        a_err[i]   = err;
    endtask

    logic [31:0]  cnt_before;
    logic [N-1:0] seq [6];

    initial begin
        rst     = 1'b1;
        exc_ack = 1'b0;
        ch_req  = '0;
        for (int i = 0; i < N; i++) set_ch(i, 1'b0, '0, '0, 1'b0);

        // Reset state
        step(0);
        chk("rst_wb_en", 64'(wb_en), 64'd0);
        chk("rst_ch_clear", 64'(ch_clear), 64'd0);
        chk("rst_exc_valid", 64'(exc_valid), 64'd0);
        chk("rst_commit_cnt", 64'(commit_cnt), 64'd0);
        rst = 1'b0;

        // 1: single result on ch1
        set_ch(1, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
        step(1);
        chk("t1_wb_en", 64'(wb_en), 64'd1);
        chk("t1_wb_rd", 64'(wb_rd), 64'd7);
        chk("t1_wb_data", 64'(wb_data), 64'hDEADBEEF);
        chk("t1_clear", 64'(ch_clear), 64'b0010);
        chk("t1_cnt", 64'(commit_cnt), 64'd1);
        step(1);
        chk("t1_idle_wb_en", 64'(wb_en), 64'd0);
        chk("t1_hold_wb_rd", 64'(wb_rd), 64'd7);

        // 2: fairness with all four held valid from reset
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_ch(i, 1'b1, RW'(i + 1), 32'h1000 + i, 1'b0);
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
        seq[3] = 4'b1000; seq[4] = 4'b0001; seq[5] = 4'b0010;
        for (int s = 0; s < 6; s++) begin
            step(0);
            chk("t2_rr_order", 64'(ch_clear), 64'(seq[s]));
        end
        for (int i = 0; i < N; i++) a_valid[i] = 1'b0;
        step(0);
        // single held channel commits only every other cycle
        set_ch(0, 1'b1, 5'd3, 32'h0BAD_F00D, 1'b0);
        for (int s = 0; s < 4; s++) begin
            step(0);
            chk("t2_mask", 64'(ch_clear), (s % 2 == 0) ? 64'b0001 : 64'b0000);
        end
        a_valid[0] = 1'b0;
        step(0);

        // 3: x0 destination
        cnt_before = m_cnt;
        set_ch(2, 1'b1, 5'd0, 32'h55, 1'b0);
        step(1);
        chk("t3_wb_en", 64'(wb_en), 64'd0);
        chk("t3_clear", 64'(ch_clear), 64'b0100);
        chk("t3_cnt_inc", 64'(commit_cnt), 64'(cnt_before + 32'd1));

        // 4: error on ch3, ch0 waits for the ack
        set_ch(3, 1'b1, 5'd9, 32'h0, 1'b1);
        step(1);
        chk("t4_exc_valid", 64'(exc_valid), 64'd1);
        chk("t4_exc_ch", 64'(exc_ch), 64'd3);
        chk("t4_exc_rd", 64'(exc_rd), 64'd9);
        chk("t4_wb_en", 64'(wb_en), 64'd0);
        set_ch(0, 1'b1, 5'd5, 32'h0000ABCD, 1'b0);
        for (int s = 0; s < 3; s++) begin
            step(0);
            chk("t4_stall_clear", 64'(ch_clear), 64'd0);
        end
        exc_ack = 1'b1;
        step(1);
        exc_ack = 1'b0;
        chk("t4_ack_exc_valid", 64'(exc_valid), 64'd0);
        chk("t4_ch0_commit", 64'(wb_en), 64'd1);
        chk("t4_ch0_clear", 64'(ch_clear), 64'b0001);

        // 5: ack coincides with a new errored grant
        set_ch(3, 1'b1, 5'd4, 32'h0, 1'b1);
        step(1);
        set_ch(1, 1'b1, 5'd11, 32'h0, 1'b1);
        exc_ack = 1'b1;
        step(1);
        chk("t5_exc_valid", 64'(exc_valid), 64'd1);
        chk("t5_exc_ch", 64'(exc_ch), 64'd1);
        chk("t5_exc_rd", 64'(exc_rd), 64'd11);
        step(0);
        exc_ack = 1'b0;
        chk("t5_drained", 64'(exc_valid), 64'd0);

        // 6: reset in a grant cycle
        set_ch(2, 1'b1, 5'd3, 32'h66, 1'b0);
        step(0);
        set_ch(3, 1'b1, 5'd8, 32'h77, 1'b0);
        rst = 1'b1;
        step(0);
        chk("t6_rst_clear", 64'(ch_clear), 64'd0);
        chk("t6_rst_wb_en", 64'(wb_en), 64'd0);
        chk("t6_rst_cnt", 64'(commit_cnt), 64'd0);
        rst = 1'b0;
        step(0);
        chk("t6_regrant_ch2", 64'(ch_clear), 64'b0100);
        for (int i = 0; i < N; i++) a_valid[i] = 1'b0;
        step(0);

        // Random traffic against the model
        for (int s = 0; s < 800; s++) begin
            rst     = ($urandom_range(0, 79) == 0);
            exc_ack = ($urandom_range(0, 3) == 0);
            ch_req  = N'($urandom);
            step(2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
